cv32e41p_rf_wb_arbiter: RTL and testbench

CV32E41P_RF_WB_ARBITER -- requirements
Module: cv32e41p_rf_wb_arbiter

---
 rtl/cv32e41p_rf_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cv32e41p_rf_wb_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e41p_rf_wb_arbiter
//
// Writeback arbiter and pending-write scoreboard for the register file.
// Three writeback sources (0=ALU, 1=MULT, 2=LSU) compete for two register
// file write ports. Arbitration is round-robin from rr_ptr_q: the first valid
// requester in scan order gets port A, the second gets port B unless it targets
// the same register. Granted writes appear on the write ports one cycle later.
// The scoreboard keeps one pending bit per register. The issue stage sets a bit
// through the alloc port. A bit clears when its write leaves the write port.
// The address space is flat; when an FPU is present, the top address bit
// selects the FP bank.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid_i/_waddr_i/_wdata_i   per-requester writeback request
//   req_ready_o                 per-requester grant (combinational)
//   alloc_valid_i/alloc_addr_i  destination reservation from issue
//   raddr_{a,b,c}_i             operand addresses for hazard lookup
//   hazard_{a,b,c}_o            operand register has a pending write
//   waddr/wdata/we_{a,b}_o      register file write ports A and B
// -----------------------------------------------------------------------------
module cv32e41p_rf_wb_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_waddr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  logic                               alloc_valid_i,
   input  logic [ADDR_WIDTH-1:0]              alloc_addr_i,
   input  logic [ADDR_WIDTH-1:0]              raddr_a_i,
   input  logic [ADDR_WIDTH-1:0]              raddr_b_i,
   input  logic [ADDR_WIDTH-1:0]              raddr_c_i,
   output logic                               hazard_a_o,
   output logic                               hazard_b_o,
   output logic                               hazard_c_o,
   output logic [ADDR_WIDTH-1:0]              waddr_a_o,
   output logic [DATA_WIDTH-1:0]              wdata_a_o,
   output logic                               we_a_o,
   output logic [ADDR_WIDTH-1:0]              waddr_b_o,
   output logic [DATA_WIDTH-1:0]              wdata_b_o,
   output logic                               we_b_o
);

   localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W:0]        scan_sum;
   logic [PTR_W-1:0]      scan_idx;
   logic                  second_seen;
   logic                  gnt_a, gnt_b;
   logic [PTR_W-1:0]      idx_a, idx_b, last_idx;

   logic                  we_a_q, we_b_q;
   logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
   logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

   logic [NUM_REGS-1:0]   pending_q, pending_d;

   // Round-robin scan starting at rr_ptr_q.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      gnt_a       = 1'b0;
      gnt_b       = 1'b0;
      idx_a       = '0;
      idx_b       = '0;
      second_seen = 1'b0;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (req_valid_i[scan_idx]) begin
            if (!gnt_a) begin
               gnt_a = 1'b1;
               idx_a = scan_idx;
            end else if (!second_seen) begin
               second_seen = 1'b1;
               // A second writer to port A's register waits.
               // The two ports then never write the same register.
               if (req_waddr_i[scan_idx] != req_waddr_i[idx_a]) begin
                  gnt_b = 1'b1;
                  idx_b = scan_idx;
               end
            end
         end
      end
      // Nothing is granted while reset is applied.
      if (rst) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (gnt_a) req_ready_o[idx_a] = 1'b1;
      if (gnt_b) req_ready_o[idx_b] = 1'b1;
   end

   // The pointer moves just past the last requester granted in scan order.
   always_comb begin
      last_idx = gnt_b ? idx_b : idx_a;
      rr_ptr_d = rr_ptr_q;
      if (gnt_a) begin
         rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      end
   end

   // Scoreboard next state. The clear is applied before the set, so a new
   // reservation wins over a write to the same register in the same cycle.
   always_comb begin
      pending_d = pending_q;
      if (we_a_q) pending_d[waddr_a_q] = 1'b0;
      if (we_b_q) pending_d[waddr_b_q] = 1'b0;
      if (alloc_valid_i) pending_d[alloc_addr_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples values from before the edge regardless of statement order.
      if (rst) begin
         rr_ptr_q  <= '0;
         we_a_q    <= 1'b0;
         we_b_q    <= 1'b0;
         waddr_a_q <= '0;
         waddr_b_q <= '0;
         wdata_a_q <= '0;
         wdata_b_q <= '0;
         // NOTE: the scoreboard is a flop vector, not a RAM macro.
         // It can therefore be cleared by reset in a single cycle.
         pending_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         pending_q <= pending_d;
         // x0 is hardwired to zero: the write is accepted but never performed.
         we_a_q    <= gnt_a && (req_waddr_i[idx_a] != '0);
         we_b_q    <= gnt_b && (req_waddr_i[idx_b] != '0);
         if (gnt_a) begin
            waddr_a_q <= req_waddr_i[idx_a];
            wdata_a_q <= req_wdata_i[idx_a];
         end
         if (gnt_b) begin
            waddr_b_q <= req_waddr_i[idx_b];
            wdata_b_q <= req_wdata_i[idx_b];
         end
      end
   end

   assign hazard_a_o = pending_q[raddr_a_i];
   assign hazard_b_o = pending_q[raddr_b_i];
   assign hazard_c_o = pending_q[raddr_c_i];

   assign we_a_o    = we_a_q;
   assign waddr_a_o = waddr_a_q;
   assign wdata_a_o = wdata_a_q;
   assign we_b_o    = we_b_q;
   assign waddr_b_o = waddr_b_q;
   assign wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_cv32e41p_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for cv32e41p_rf_wb_arbiter: directed scenarios plus a randomized
// run, checked against a behavioural model (scan-order list arbitration,
// per-register pending array, expected write-port contents).
// -----------------------------------------------------------------------------
module tb_cv32e41p_rf_wb_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NR = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0][AW-1:0] req_waddr;
   logic [NR-1:0][DW-1:0] req_wdata;
   logic [NR-1:0]        req_ready;
   logic                 alloc_valid;
   logic [AW-1:0]        alloc_addr;
   logic [AW-1:0]        raddr_a, raddr_b, raddr_c;
   logic                 hazard_a, hazard_b, hazard_c;
   logic [AW-1:0]        waddr_a, waddr_b;
   logic [DW-1:0]        wdata_a, wdata_b;
   logic                 we_a, we_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int            m_ptr;
   bit            m_pending [64];
   bit            m_we_a, m_we_b;
   logic [AW-1:0] m_wa_a, m_wa_b;
   logic [DW-1:0] m_wd_a, m_wd_b;
   logic [NR-1:0] m_gnt;

   cv32e41p_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_waddr_i  (req_waddr),
      .req_wdata_i  (req_wdata),
      .req_ready_o  (req_ready),
      .alloc_valid_i(alloc_valid),
      .alloc_addr_i (alloc_addr),
      .raddr_a_i    (raddr_a),
      .raddr_b_i    (raddr_b),
      .raddr_c_i    (raddr_c),
      .hazard_a_o   (hazard_a),
      .hazard_b_o   (hazard_b),
      .hazard_c_o   (hazard_c),
      .waddr_a_o    (waddr_a),
      .wdata_a_o    (wdata_a),
      .we_a_o       (we_a),
      .waddr_b_o    (waddr_b),
      .wdata_b_o    (wdata_b),
      .we_b_o       (we_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

   // Expected grants: list the valid requesters in scan order from the model
   // pointer. The first is granted; the second only if its address differs.
   function automatic logic [NR-1:0] exp_ready();
      int order[$];
      logic [NR-1:0] r;
      r = '0;
      if (rst) return r;
      for (int k = 0; k < NR; k++) begin
         if (req_valid[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
      end
      if (order.size() > 0) r[order[0]] = 1'b1;
      if (order.size() > 1 && req_waddr[order[1]] != req_waddr[order[0]]) r[order[1]] = 1'b1;
      return r;
   endfunction

   // Advance one clock: update the model with the inputs present at the edge,
   // then return 1 time unit after the edge so the caller can drive new inputs.
   task automatic tick();
      logic [NR-1:0] g;
      int first, second;
      g = exp_ready();
      first = -1;
      second = -1;
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (m_ptr + k) % NR;
         if (g[j]) begin
            if (first < 0) first = j;
            else second = j;
         end
      end
      @(posedge clk);
      m_gnt = g;
      if (rst) begin
         m_ptr = 0;
         foreach (m_pending[i]) m_pending[i] = 1'b0;
         m_we_a = 1'b0; m_we_b = 1'b0;
         m_wa_a = '0;   m_wa_b = '0;
         m_wd_a = '0;   m_wd_b = '0;
         m_gnt  = '0;
      end else begin
         if (m_we_a) m_pending[m_wa_a] = 1'b0;
         if (m_we_b) m_pending[m_wa_b] = 1'b0;
         if (alloc_valid && alloc_addr != 0) m_pending[alloc_addr] = 1'b1;
         m_we_a = 1'b0;
         m_we_b = 1'b0;
         if (first >= 0) begin
            m_we_a = (req_waddr[first] != 0);
            m_wa_a = req_waddr[first];
            m_wd_a = req_wdata[first];
            m_ptr  = (((second >= 0) ? second : first) + 1) % NR;
         end
         if (second >= 0) begin
            m_we_b = (req_waddr[second] != 0);
            m_wa_b = req_waddr[second];
            m_wd_b = req_wdata[second];
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_waddr = '0; req_wdata = '0;
      alloc_valid = 1'b0; alloc_addr = '0;
      raddr_a = '0; raddr_b = '0; raddr_c = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 3'b111;
      req_waddr = {6'd3, 6'd2, 6'd1};
      alloc_valid = 1'b1;
      alloc_addr  = 6'd3;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b expected 000", req_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      req_valid = '0;
      alloc_valid = 1'b0;
      raddr_a = 6'd3; raddr_b = 6'd1; raddr_c = 6'd2;
      @(negedge clk);
      n_checks++;
      if ({we_a, we_b, waddr_a, waddr_b, wdata_a, wdata_b} !== '0)
         $display("FAIL reset_ports: got we=%b%b wa=%h wb=%h da=%h db=%h expected all 0",
                  we_a, we_b, waddr_a, waddr_b, wdata_a, wdata_b);
      else n_pass++;
      n_checks++;
      if ({hazard_a, hazard_b, hazard_c} !== 3'b000)
         $display("FAIL reset_hazard: got %b expected 000", {hazard_a, hazard_b, hazard_c});
      else n_pass++;
      tick();
   endtask

   task automatic test_three_way();
      do_reset();
      req_valid = 3'b111;
      req_waddr = {6'd7, 6'd6, 6'd5};
      req_wdata = {32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005};
      @(negedge clk);
      n_checks++;
      if (req_ready !== 3'b011) $display("FAIL rr3_ready: got %b expected 011", req_ready);
      else n_pass++;
      tick();
      // ALU and MULT return with new requests; only rr_ptr=2 yields 101.
      req_waddr = {6'd7, 6'd11, 6'd10};
      req_wdata = {32'hC0DE_0007, 32'hC0DE_000B, 32'hC0DE_000A};
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, wdata_a} !== {1'b1, 6'd5, 32'hC0DE_0005})
         $display("FAIL rr3_port_a: got %b/%0d/%h expected 1/5/c0de0005", we_a, waddr_a, wdata_a);
      else n_pass++;
      n_checks++;
      if ({we_b, waddr_b, wdata_b} !== {1'b1, 6'd6, 32'hC0DE_0006})
         $display("FAIL rr3_port_b: got %b/%0d/%h expected 1/6/c0de0006", we_b, waddr_b, wdata_b);
      else n_pass++;
      n_checks++;
      if (req_ready !== 3'b101) $display("FAIL rr3_ptr2_ready: got %b expected 101", req_ready);
      else n_pass++;
      tick();
      req_valid = 3'b010;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b} !==
          {1'b1, 6'd7, 32'hC0DE_0007, 1'b1, 6'd10, 32'hC0DE_000A})
         $display("FAIL rr3_lsu_write: got A=%b/%0d/%h B=%b/%0d/%h expected A=1/7 B=1/10",
                  we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b);
      else n_pass++;
      n_checks++;
      if (req_ready !== 3'b010) $display("FAIL rr3_mult_ready: got %b expected 010", req_ready);
      else n_pass++;
      tick();
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, we_b} !== {1'b1, 6'd11, 1'b0})
         $display("FAIL rr3_mult_write: got we_a=%b wa=%0d we_b=%b expected 1/11/0", we_a, waddr_a, we_b);
      else n_pass++;
      tick();
   endtask

   task automatic test_same_addr();
      do_reset();
      req_valid = 3'b011;
      req_waddr = {6'd0, 6'd9, 6'd9};
      req_wdata = {32'h0, 32'hA2A2_A2A2, 32'hA1A1_A1A1};
      @(negedge clk);
      n_checks++;
      if (req_ready !== 3'b001) $display("FAIL same_ready0: got %b expected 001", req_ready);
      else n_pass++;
      tick();
      req_valid = 3'b010;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, wdata_a, we_b} !== {1'b1, 6'd9, 32'hA1A1_A1A1, 1'b0})
         $display("FAIL same_write1: got A=%b/%0d/%h we_b=%b expected A=1/9/a1a1a1a1 we_b=0",
                  we_a, waddr_a, wdata_a, we_b);
      else n_pass++;
      n_checks++;
      if (req_ready !== 3'b010) $display("FAIL same_ready1: got %b expected 010", req_ready);
      else n_pass++;
      tick();
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, wdata_a, we_b} !== {1'b1, 6'd9, 32'hA2A2_A2A2, 1'b0})
         $display("FAIL same_write2: got A=%b/%0d/%h we_b=%b expected A=1/9/a2a2a2a2 we_b=0",
                  we_a, waddr_a, wdata_a, we_b);
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({we_a, we_b} !== 2'b00) $display("FAIL same_idle: got we=%b%b expected 00", we_a, we_b);
      else n_pass++;
      tick();
   endtask

   task automatic test_hazard();
      do_reset();
      alloc_valid = 1'b1; alloc_addr = 6'd12;
      raddr_a = 6'd12; raddr_b = 6'd12; raddr_c = 6'd13;
      @(negedge clk);
      n_checks++;
      if (hazard_a !== 1'b0) $display("FAIL haz_c0: got %b expected 0", hazard_a);
      else n_pass++;
      tick();
      alloc_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({hazard_a, hazard_b, hazard_c} !== 3'b110)
         $display("FAIL haz_c1: got %b expected 110", {hazard_a, hazard_b, hazard_c});
      else n_pass++;
      tick();
      tick();
      req_valid = 3'b100;
      req_waddr[2] = 6'd12;
      req_wdata[2] = 32'h1234_5678;
      @(negedge clk);
      n_checks++;
      if ({req_ready, hazard_a} !== {3'b100, 1'b1})
         $display("FAIL haz_c3: got ready=%b hazard_a=%b expected 100/1", req_ready, hazard_a);
      else n_pass++;
      tick();
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, hazard_a} !== {1'b1, 6'd12, 1'b1})
         $display("FAIL haz_c4: got we_a=%b wa=%0d hazard_a=%b expected 1/12/1", we_a, waddr_a, hazard_a);
      else n_pass++;
      tick();
      @(negedge clk);
      n_checks++;
      if ({hazard_a, hazard_b} !== 2'b00)
         $display("FAIL haz_c5: got %b expected 00", {hazard_a, hazard_b});
      else n_pass++;
      tick();
   endtask

   task automatic test_set_clear();
      do_reset();
      alloc_valid = 1'b1; alloc_addr = 6'd8; raddr_b = 6'd8;
      tick();
      alloc_valid = 1'b0;
      req_valid = 3'b001; req_waddr[0] = 6'd8; req_wdata[0] = 32'h0000_0808;
      tick();
      req_valid = '0;
      alloc_valid = 1'b1; alloc_addr = 6'd8;
      @(negedge clk);
      n_checks++;
      if ({we_a, waddr_a, hazard_b} !== {1'b1, 6'd8, 1'b1})
         $display("FAIL setclr_write: got we_a=%b wa=%0d hazard_b=%b expected 1/8/1", we_a, waddr_a, hazard_b);
      else n_pass++;
      tick();
      alloc_valid = 1'b0;
      req_valid = 3'b001;
      @(negedge clk);
      n_checks++;
      if (hazard_b !== 1'b1) $display("FAIL setclr_kept: got %b expected 1", hazard_b);
      else n_pass++;
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      n_checks++;
      if (hazard_b !== 1'b0) $display("FAIL setclr_cleared: got %b expected 0", hazard_b);
      else n_pass++;
      tick();
   endtask

   task automatic test_x0();
      do_reset();
      req_valid = 3'b001; req_waddr[0] = 6'd0; req_wdata[0] = 32'hDEAD_BEEF;
      alloc_valid = 1'b1; alloc_addr = 6'd0; raddr_c = 6'd0;
      @(negedge clk);
      n_checks++;
      if ({req_ready, hazard_c} !== {3'b001, 1'b0})
         $display("FAIL x0_ready: got ready=%b hazard_c=%b expected 001/0", req_ready, hazard_c);
      else n_pass++;
      tick();
      req_valid = '0; alloc_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({we_a, we_b, hazard_c} !== 3'b000)
         $display("FAIL x0_nowrite: got we=%b%b hazard_c=%b expected 000", we_a, we_b, hazard_c);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      alloc_valid = 1'b1; alloc_addr = 6'd20; raddr_a = 6'd20;
      tick();
      alloc_valid = 1'b0;
      req_valid = 3'b111; req_waddr = {6'd23, 6'd22, 6'd21};
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({req_ready, hazard_a} !== {3'b000, 1'b1})
         $display("FAIL rstmid_ready: got ready=%b hazard_a=%b expected 000/1", req_ready, hazard_a);
      else n_pass++;
      tick();
      rst = 1'b0; req_valid = '0;
      @(negedge clk);
      n_checks++;
      if ({we_a, we_b, hazard_a} !== 3'b000)
         $display("FAIL rstmid_after: got we=%b%b hazard_a=%b expected 000", we_a, we_b, hazard_a);
      else n_pass++;
      tick();
   endtask

   task automatic test_fairness();
      int cnt[NR];
      int waits[NR];
      int max_wait;
      do_reset();
      foreach (cnt[i]) begin cnt[i] = 0; waits[i] = 0; end
      max_wait = 0;
      req_valid = 3'b111;
      req_waddr = {6'd3, 6'd2, 6'd1};
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < NR; i++) req_wdata[i] = $urandom;
         @(negedge clk);
         n_checks++;
         if (req_ready !== exp_ready())
            $display("FAIL fair_ready cycle %0d: got %b expected %b", c, req_ready, exp_ready());
         else n_pass++;
         for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
               cnt[i]++;
               waits[i] = 0;
            end else begin
               waits[i]++;
               if (waits[i] > max_wait) max_wait = waits[i];
            end
         end
         tick();
      end
      req_valid = '0;
      for (int i = 0; i < NR; i++) begin
         n_checks++;
         if (cnt[i] != 20) $display("FAIL fair_count req %0d: got %0d expected 20", i, cnt[i]);
         else n_pass++;
      end
      n_checks++;
      if (max_wait > 1) $display("FAIL fair_wait: got %0d expected at most 1", max_wait);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || m_gnt[i]) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               req_waddr[i] = AW'($urandom_range(0, 7));
               req_wdata[i] = $urandom;
            end
         end
         alloc_valid = $urandom_range(0, 1) == 1;
         alloc_addr  = AW'($urandom_range(0, 7));
         raddr_a = AW'($urandom_range(0, 7));
         raddr_b = AW'($urandom_range(0, 7));
         raddr_c = AW'($urandom_range(0, 7));
         @(negedge clk);
         n_checks++;
         if (req_ready !== exp_ready())
            $display("FAIL rnd_ready cycle %0d: got %b expected %b", c, req_ready, exp_ready());
         else n_pass++;
         n_checks++;
         if (we_a !== m_we_a || (m_we_a && {waddr_a, wdata_a} !== {m_wa_a, m_wd_a}))
            $display("FAIL rnd_port_a cycle %0d: got %b/%0d/%h expected %b/%0d/%h",
                     c, we_a, waddr_a, wdata_a, m_we_a, m_wa_a, m_wd_a);
         else n_pass++;
         n_checks++;
         if (we_b !== m_we_b || (m_we_b && {waddr_b, wdata_b} !== {m_wa_b, m_wd_b}))
            $display("FAIL rnd_port_b cycle %0d: got %b/%0d/%h expected %b/%0d/%h",
                     c, we_b, waddr_b, wdata_b, m_we_b, m_wa_b, m_wd_b);
         else n_pass++;
         n_checks++;
         if ({hazard_a, hazard_b, hazard_c} !== {m_pending[raddr_a], m_pending[raddr_b], m_pending[raddr_c]})
            $display("FAIL rnd_hazard cycle %0d: got %b expected %b", c, {hazard_a, hazard_b, hazard_c},
                     {m_pending[raddr_a], m_pending[raddr_b], m_pending[raddr_c]});
         else n_pass++;
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      m_ptr = 0;
      foreach (m_pending[i]) m_pending[i] = 1'b0;
      m_we_a = 1'b0; m_we_b = 1'b0;
      m_wa_a = '0;   m_wa_b = '0;
      m_wd_a = '0;   m_wd_b = '0;
      m_gnt  = '0;
      #1;
      test_reset();
      test_three_way();
      test_same_addr();
      test_hazard();
      test_set_clear();
      test_x0();
      test_reset_mid();
      test_fairness();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
